sys_cmd_host: RTL and testbench

Host-side command initiator for the system's UART command protocol, the other end of the system controller. It accepts one parallel command (register write, register read, ALU with operands, ALU without operands) and serialises it into the protocol's frame bytes for a UART transmitter. It then collects the response bytes from a UART receiver and returns a single parallel result. It sits in the test/host fabric between a stimulus or CPU interface and a UART TX/RX pair running on the same clock.

---
 rtl/sys_cmd_pkg.sv | 52 +++++
 rtl/sys_cmd_timer.sv | 33 +++
 rtl/sys_cmd_host.sv | 173 +++++++++++++++++
 tb/tb_sys_cmd_host.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_cmd_pkg.sv
// Shared types for the UART command host: opcodes, command encoding,
// FSM states and frame/response length helpers.
package sys_cmd_pkg;

  localparam logic [7:0] RF_WR_CMD   = 8'hAA;
  localparam logic [7:0] RF_RD_CMD   = 8'hBB;
  localparam logic [7:0] ALU_OP_CMD  = 8'hCC;
  localparam logic [7:0] ALU_NOP_CMD = 8'hDD;

  typedef enum logic [1:0] {
    RF_WR   = 2'd0,
    RF_RD   = 2'd1,
    ALU_OP  = 2'd2,
    ALU_NOP = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO,
    S_RECV,
    S_DONE
  } state_e;

  function automatic logic [2:0] frame_len(input cmd_type_e t);
    case (t)
      RF_WR:   return 3'd3;
      RF_RD:   return 3'd2;
      ALU_OP:  return 3'd4;
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic [1:0] rsp_len(input cmd_type_e t);
    case (t)
      RF_WR:   return 2'd0;
      RF_RD:   return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  function automatic logic [7:0] opcode(input cmd_type_e t);
    case (t)
      RF_WR:   return RF_WR_CMD;
      RF_RD:   return RF_RD_CMD;
      ALU_OP:  return ALU_OP_CMD;
      default: return ALU_NOP_CMD;
    endcase
  endfunction

endpackage

// File: rtl/sys_cmd_timer.sv
// Response-wait watchdog for sys_cmd_host; only built when
// SYS_CMD_HOST_TIMEOUT_EN is defined.
`ifdef SYS_CMD_HOST_TIMEOUT_EN
module sys_cmd_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic expired
);

  localparam int CW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || restart) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = run && !restart && (cnt == LAST);

endmodule
`endif

// File: rtl/sys_cmd_host.sv
// Host-side UART command initiator: serialises one command into frame
// bytes and collects the response. Option: SYS_CMD_HOST_TIMEOUT_EN.
module sys_cmd_host
  import sys_cmd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR           = 4,
  parameter int unsigned ALU_OUT_WIDTH  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CMD_VLD,
  output logic                     CMD_RDY,
  input  logic [1:0]               CMD_TYPE,
  input  logic [ADDR-1:0]          CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]    CMD_DATA,
  input  logic [DATA_WIDTH-1:0]    CMD_OPB,
  input  logic [3:0]               CMD_FUN,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD,
  input  logic                     TX_BUSY,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  output logic [ALU_OUT_WIDTH-1:0] RSP_DATA,
  output logic                     RSP_VLD,
  output logic                     RSP_TIMEOUT
);

  state_e                   state, state_nx;
  cmd_type_e                typ_q, t;
  logic [ADDR-1:0]          addr_q, a;
  logic [DATA_WIDTH-1:0]    data_q, d;
  logic [DATA_WIDTH-1:0]    opb_q, b;
  logic [3:0]               fun_q, f;
  logic [2:0]               len_q;
  logic [2:0]               idx_q, idx_nx;
  logic [1:0]               rcnt_q, rcnt_nx;
  logic [ALU_OUT_WIDTH-1:0] buf_q, buf_nx;
  logic [DATA_WIDTH-1:0]    byte_nx;
  logic                     ld;
  logic                     tmo_nx;
  logic                     expired;

`ifdef SYS_CMD_HOST_TIMEOUT_EN
  sys_cmd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (CLK),
    .rst    (RST),
    .run    (state == S_RECV),
    .restart(RX_D_VLD),
    .expired(expired)
  );
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = TIMEOUT_CYCLES;
  assign expired    = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    idx_nx   = idx_q;
    rcnt_nx  = rcnt_q;
    buf_nx   = buf_q;
    ld       = 1'b0;
    tmo_nx   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (CMD_VLD && CMD_RDY) begin
          ld       = 1'b1;
          idx_nx   = '0;
          rcnt_nx  = '0;
          buf_nx   = '0;
          state_nx = S_SEND;
        end
      end
      S_SEND: state_nx = S_WAIT_HI;
      S_WAIT_HI: begin
        if (TX_BUSY) state_nx = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!TX_BUSY) begin
          if (idx_q + 3'd1 < len_q) begin
            idx_nx   = idx_q + 3'd1;
            state_nx = S_SEND;
          end else if (rsp_len(typ_q) == 2'd0) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (RX_D_VLD) begin
          if (rcnt_q == 2'd0)
            buf_nx[DATA_WIDTH-1:0] = RX_P_DATA;
          else
            buf_nx[DATA_WIDTH +: DATA_WIDTH] = RX_P_DATA;
          rcnt_nx = rcnt_q + 2'd1;
          if (rcnt_nx == rsp_len(typ_q)) state_nx = S_DONE;
        end else if (expired) begin
          tmo_nx   = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Byte for the next SEND; fields come straight from the inputs on accept
  always_comb begin
    t       = ld ? cmd_type_e'(CMD_TYPE) : typ_q;
    a       = ld ? CMD_ADDR : addr_q;
    d       = ld ? CMD_DATA : data_q;
    b       = ld ? CMD_OPB : opb_q;
    f       = ld ? CMD_FUN : fun_q;
    byte_nx = '0;
    case (idx_nx)
      3'd0: byte_nx = DATA_WIDTH'(opcode(t));
      3'd1: begin
        if (t == ALU_NOP)     byte_nx = DATA_WIDTH'(f);
        else if (t == ALU_OP) byte_nx = d;
        else                  byte_nx = DATA_WIDTH'(a);
      end
      3'd2:    byte_nx = (t == ALU_OP) ? b : d;
      3'd3:    byte_nx = DATA_WIDTH'(f);
      default: byte_nx = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      typ_q       <= RF_WR;
      addr_q      <= '0;
      data_q      <= '0;
      opb_q       <= '0;
      fun_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      rcnt_q      <= '0;
      buf_q       <= '0;
      CMD_RDY     <= 1'b0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
      RSP_DATA    <= '0;
      RSP_VLD     <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
    end else begin
      state  <= state_nx;
      idx_q  <= idx_nx;
      rcnt_q <= rcnt_nx;
      buf_q  <= buf_nx;
      if (ld) begin
        typ_q  <= t;
        addr_q <= a;
        data_q <= d;
        opb_q  <= b;
        fun_q  <= f;
        len_q  <= frame_len(t);
      end
      CMD_RDY  <= (state_nx == S_IDLE);
      TX_D_VLD <= (state_nx == S_SEND);
      if (state_nx == S_SEND) TX_P_DATA <= byte_nx;
      RSP_VLD     <= (state_nx == S_DONE);
      RSP_TIMEOUT <= tmo_nx;
      if (state_nx == S_DONE) RSP_DATA <= buf_nx;
    end
  end

endmodule

// File: tb/tb_sys_cmd_host.sv
// Directed bench for sys_cmd_host: vector table of commands plus
// reset-abort and no-reply sequences.
module tb_sys_cmd_host;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CMD_VLD;
  logic        CMD_RDY;
  logic [1:0]  CMD_TYPE;
  logic [3:0]  CMD_ADDR;
  logic [7:0]  CMD_DATA;
  logic [7:0]  CMD_OPB;
  logic [3:0]  CMD_FUN;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_BUSY;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [15:0] RSP_DATA;
  logic        RSP_VLD;
  logic        RSP_TIMEOUT;

  always #5 CLK = ~CLK;

  sys_cmd_host #(
    .DATA_WIDTH    (8),
    .ADDR          (4),
    .ALU_OUT_WIDTH (16),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .CMD_VLD    (CMD_VLD),
    .CMD_RDY    (CMD_RDY),
    .CMD_TYPE   (CMD_TYPE),
    .CMD_ADDR   (CMD_ADDR),
    .CMD_DATA   (CMD_DATA),
    .CMD_OPB    (CMD_OPB),
    .CMD_FUN    (CMD_FUN),
    .TX_P_DATA  (TX_P_DATA),
    .TX_D_VLD   (TX_D_VLD),
    .TX_BUSY    (TX_BUSY),
    .RX_P_DATA  (RX_P_DATA),
    .RX_D_VLD   (RX_D_VLD),
    .RSP_DATA   (RSP_DATA),
    .RSP_VLD    (RSP_VLD),
    .RSP_TIMEOUT(RSP_TIMEOUT)
  );

  // UART TX model: busy for busy_len cycles after each byte
  int         busy_len = 10;
  int         busy_cnt;
  logic [7:0] txq[$];

  always @(posedge CLK or posedge RST) begin
    if (RST) busy_cnt <= 0;
    else if (TX_D_VLD) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign TX_BUSY = (busy_cnt != 0);

  always @(posedge CLK) begin
    if (!RST && TX_D_VLD) txq.push_back(TX_P_DATA);
  end

  int rsp_cnt = 0;
  int tmo_cnt = 0;
  always @(posedge CLK) begin
    if (RSP_VLD) rsp_cnt <= rsp_cnt + 1;
    if (RSP_TIMEOUT) tmo_cnt <= tmo_cnt + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] t, input logic [3:0] a,
                       input logic [7:0] d, input logic [7:0] b,
                       input logic [3:0] f);
    @(negedge CLK);
    check("cmd_rdy_before", CMD_RDY, 1);
    CMD_TYPE = t;
    CMD_ADDR = a;
    CMD_DATA = d;
    CMD_OPB  = b;
    CMD_FUN  = f;
    CMD_VLD  = 1'b1;
    @(negedge CLK);
    CMD_VLD  = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (!(txq.size() == n && !TX_BUSY) && k < 2000) begin
      @(negedge CLK);
      k++;
    end
    check("tx_wait_expired", k >= 2000, 0);
  endtask

  task automatic send_rx(input logic [7:0] v);
    RX_P_DATA = v;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  typ;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic [7:0]  opb;
    logic [3:0]  fun;
    logic        stray;
    int          nrx;
    logic [7:0]  rx0;
    logic [7:0]  rx1;
    int          ntx;
    logic [31:0] txw;
    logic [15:0] rsp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int c0;
    int k;
    RST       = 1'b1;
    CMD_VLD   = 1'b0;
    CMD_TYPE  = '0;
    CMD_ADDR  = '0;
    CMD_DATA  = '0;
    CMD_OPB   = '0;
    CMD_FUN   = '0;
    RX_P_DATA = '0;
    RX_D_VLD  = 1'b0;

    vecs[0] = '{2'd0, 4'h2, 8'h81, 8'h00, 4'h0, 1'b0, 0, 8'h00, 8'h00,
                3, 32'hAA028100, 16'h0000};
    vecs[1] = '{2'd1, 4'h3, 8'h00, 8'h00, 4'h0, 1'b0, 1, 8'h20, 8'h00,
                2, 32'hBB030000, 16'h0020};
    vecs[2] = '{2'd2, 4'h0, 8'h05, 8'h03, 4'h0, 1'b0, 2, 8'h08, 8'h00,
                4, 32'hCC050300, 16'h0008};
    vecs[3] = '{2'd3, 4'h0, 8'h00, 8'h00, 4'h2, 1'b1, 2, 8'h0F, 8'h01,
                2, 32'hDD020000, 16'h010F};
    vecs[4] = '{2'd1, 4'hF, 8'h99, 8'h77, 4'h5, 1'b0, 1, 8'hFF, 8'h00,
                2, 32'hBB0F0000, 16'h00FF};
    vecs[5] = '{2'd2, 4'h9, 8'hFF, 8'h80, 4'hF, 1'b0, 2, 8'h34, 8'h12,
                4, 32'hCCFF800F, 16'h1234};
    vecs[6] = '{2'd0, 4'hF, 8'h00, 8'h55, 4'h7, 1'b0, 0, 8'h00, 8'h00,
                3, 32'hAA0F0000, 16'h0000};

    repeat (2) @(negedge CLK);
    check("rst_cmd_rdy", CMD_RDY, 0);
    check("rst_tx_vld", TX_D_VLD, 0);
    check("rst_tx_data", TX_P_DATA, 0);
    check("rst_rsp_vld", RSP_VLD, 0);
    check("rst_rsp_data", RSP_DATA, 0);
    check("rst_rsp_tmo", RSP_TIMEOUT, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("cmd_rdy_after_rst", CMD_RDY, 1);

    for (int i = 0; i < 7; i++) begin
      vec_t v;
      v  = vecs[i];
      txq.delete();
      c0 = rsp_cnt;
      issue(v.typ, v.addr, v.data, v.opb, v.fun);
      check($sformatf("v%0d_tx_vld_lat", i), TX_D_VLD, 1);
      check($sformatf("v%0d_tx_first", i), TX_P_DATA, v.txw[31:24]);
      if (v.stray) begin
        RX_P_DATA = 8'hEE;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
      end
      wait_tx(v.ntx);
      check($sformatf("v%0d_tx_len", i), txq.size(), v.ntx);
      for (int j = 0; j < v.ntx && j < txq.size(); j++)
        check($sformatf("v%0d_tx_b%0d", i, j), txq[j],
              v.txw[31-8*j -: 8]);
      if (v.nrx == 0) begin
        k = 0;
        while (!RSP_VLD && k < 100) begin
          @(negedge CLK);
          k++;
        end
        check($sformatf("v%0d_wr_rsp_lat", i), k, 1);
      end else begin
        repeat (2) @(negedge CLK);
        send_rx(v.rx0);
        if (v.nrx > 1) send_rx(v.rx1);
      end
      check($sformatf("v%0d_rsp_vld", i), RSP_VLD, 1);
      check($sformatf("v%0d_rsp_data", i), RSP_DATA, v.rsp);
      check($sformatf("v%0d_rdy_in_done", i), CMD_RDY, 0);
      @(negedge CLK);
      check($sformatf("v%0d_rsp_pulse", i), RSP_VLD, 0);
      check($sformatf("v%0d_rdy_back", i), CMD_RDY, 1);
      check($sformatf("v%0d_rsp_hold", i), RSP_DATA, v.rsp);
      check($sformatf("v%0d_rsp_count", i), rsp_cnt - c0, 1);
    end

    // Abort an ALU_OP after its second byte, then run RF_RD
    txq.delete();
    c0 = rsp_cnt;
    issue(2'd2, 4'h0, 8'h11, 8'h22, 4'h3);
    k = 0;
    while (txq.size() < 2 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check("abort_second_byte", txq.size(), 2);
    RST = 1'b1;
    #1;
    check("abort_cmd_rdy", CMD_RDY, 0);
    check("abort_tx_vld", TX_D_VLD, 0);
    check("abort_tx_data", TX_P_DATA, 0);
    check("abort_rsp_vld", RSP_VLD, 0);
    check("abort_rsp_data", RSP_DATA, 0);
    check("abort_rsp_tmo", RSP_TIMEOUT, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    txq.delete();
    @(negedge CLK);
    issue(2'd1, 4'h3, 8'h00, 8'h00, 4'h0);
    check("abort_next_first", TX_P_DATA, 8'hBB);
    wait_tx(2);
    check("abort_next_len", txq.size(), 2);
    if (txq.size() == 2) begin
      check("abort_next_b0", txq[0], 8'hBB);
      check("abort_next_b1", txq[1], 8'h03);
    end
    repeat (2) @(negedge CLK);
    send_rx(8'h55);
    check("abort_next_vld", RSP_VLD, 1);
    check("abort_next_data", RSP_DATA, 16'h0055);
    @(negedge CLK);
    check("abort_rsp_count", rsp_cnt - c0, 1);

    // RF_RD with no reply
    txq.delete();
    c0 = rsp_cnt;
    issue(2'd1, 4'h1, 8'h00, 8'h00, 4'h0);
    wait_tx(2);
`ifdef SYS_CMD_HOST_TIMEOUT_EN
    k = 0;
    while (!RSP_VLD && k < 100) begin
      @(negedge CLK);
      k++;
    end
    check("tmo_latency", k, 17);
    check("tmo_flag", RSP_TIMEOUT, 1);
    check("tmo_data", RSP_DATA, 16'h0000);
    @(negedge CLK);
    check("tmo_pulse", RSP_TIMEOUT, 0);
    check("tmo_total", tmo_cnt, 1);
`else
    CMD_VLD  = 1'b1;
    CMD_TYPE = 2'd0;
    repeat (3) @(negedge CLK);
    CMD_VLD  = 1'b0;
    repeat (37) @(negedge CLK);
    check("wait_no_rsp", rsp_cnt - c0, 0);
    check("wait_cmd_ignored", txq.size(), 2);
    send_rx(8'h5A);
    check("late_rsp_vld", RSP_VLD, 1);
    check("late_rsp_data", RSP_DATA, 16'h005A);
    @(negedge CLK);
    check("tmo_total", tmo_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
